dmem_unit: RTL and testbench
============================

Name: dmem_unit

Overview:
- Data-memory stage directly downstream of the ALU in the single-cycle RV32I core.
- Uses ALUResult as the byte address and performs RV32I loads and stores: lb/lh/lw/lbu/lhu and sb/sh/sw.
- Models a memory with programmable wait states. Raises Stall so the core holds its PC until the access completes.
- Flags misaligned, out-of-range and illegal-funct3 accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words of RAM; byte addresses 0 .. 4*DEPTH_WORDS-1 are valid.
- WAIT_STATES, 0, extra cycles between request acceptance and completion (0..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemReq  input  1  the current instruction is a load or store.
- MemWrite  input  1  1 = store, 0 = load; qualified by MemReq.
- Funct3  input  3  instruction funct3; selects width and sign extension.
- Addr  input  32  byte address (ALUResult).
- WriteData  input  32  store data (rs2); low bytes are used for sb/sh.
- ReadData  output  32  load result, sign- or zero-extended; valid when MemDone=1.
- MemDone  output  1  one-cycle pulse: access complete.
- Stall  output  1  combinational; core must hold PC and all inputs while high.
- Fault  output  1  one-cycle pulse, coincident with MemDone, for a rejected access.

Behaviour:
- Clocking and reset are fixed: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, wait counter 0, ReadData 0, MemDone 0, Fault 0.
- RAM contents are not reset.
- Reset asserted in any state aborts the access: no write occurs, and the next cycle is IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - MemReq=1 captures MemWrite, Funct3, Addr and WriteData, and loads the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else DONE.
  - MemReq=0: stay in IDLE.
- WAIT: decrement the counter; when it reaches 1, go to DONE. The access is performed on the edge entering DONE.
- DONE: MemDone=1 for exactly one cycle, then unconditional return to IDLE. MemReq seen during DONE is not a new request.
- Stall = MemReq & (state != DONE).
- Latency from request to MemDone is WAIT_STATES+1 cycles. Stall is high for WAIT_STATES+1 cycles.
- Back-to-back accesses are accepted in the IDLE cycle after DONE.
- Legal Funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Anything else is illegal.
- Alignment rules:
  - Halfword access requires Addr[0]=0.
  - Word access requires Addr[1:0]=00.
  - Byte access is always aligned.
- Range rule: Addr[31:2] < DEPTH_WORDS.
- Misaligned, out-of-range or illegal access:
  - No RAM write.
  - DONE is still reached after the same latency.
  - In DONE: Fault=1, ReadData=0.
- Stores: byte enables are derived from Addr[1:0] and size.
  - sb writes WriteData[7:0] into lane Addr[1:0].
  - sh writes WriteData[15:0] into lanes {Addr[1],0} and {Addr[1],1}.
  - sw writes all four lanes.
  - Other bytes in the word are untouched.
- Loads: the selected byte or halfword is right-justified.
  - lb and lh sign-extend from bit 7 or bit 15.
  - lbu and lhu zero-extend.
  - ReadData is registered and held until the next DONE or reset.
- Stores leave ReadData at its previous value.
- Little-endian byte ordering throughout.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Address 0xFFFF_FFFC is a 32-bit MMIO register; only word access is legal there.
  - sw updates the register, and its value drives an extra output port MmioOut[31:0] (reset value 0).
  - lw returns its current value.
  - sb/sh to this address raise Fault.
- Undefined: the port is absent, and the address is an ordinary out-of-range access that raises Fault.

Decomposition:
- Package dmem_pkg holds:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum.
  - MMIO_ADDR constant.
  - Functions for byte-enable generation and load extension.
- Sub-module dmem_ram: single-port, DEPTH_WORDS x 32 synchronous-write RAM with a 4-bit byte-enable and combinational read. It is instantiated once.

Test Plan:
- WAIT_STATES=0: sw 0xDEADBEEF to 0x10, then lw 0x10 → ReadData=0xDEADBEEF. Stall is high 1 cycle per access and MemDone pulses in cycle 1.
- After the above: lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x12 → 0xFFFFDEAD; lhu 0x10 → 0x0000BEEF.
- sb 0x55 to 0x11, then lw 0x10 → 0xDEAD55EF. Other lanes are unchanged.
- WAIT_STATES=3: lw → Stall high 4 cycles and MemDone in cycle 4. Assert reset in cycle 2 of a sw → no write; a later lw returns the old data.
- lw 0x12 (misaligned), lw 4*DEPTH_WORDS (out of range), Funct3=011 → Fault and MemDone together, ReadData=0, RAM unchanged.
- With DMEM_MMIO_EN: sw 0x000000A5 to 0xFFFFFFFC → MmioOut=0x000000A5 and lw returns it; sb to the same address → Fault.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and lane helpers for the dmem_unit data-memory stage.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    // Size comes from funct3[1:0]; 00 = byte, 01 = halfword, otherwise word.
    function automatic logic [3:0] byte_en(input logic [1:0] lo, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_BU:   return {24'd0, b};
            F3_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous byte-enabled write, combinational read, no reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] index,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_unit.sv
// RV32I data-memory stage with programmable wait states and access fault detection.
// Optional memory-mapped output register at MMIO_ADDR when DMEM_MMIO_EN is defined.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemDone,
    output logic        Stall,
    output logic        Fault
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] MmioOut
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

    state_t      state, next_state;
    logic [7:0]  wait_cnt;
    logic        req_write, fault_q;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        acc_write, f3_ok, aligned, in_range, legal, finish_access, ram_we;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr, acc_wdata, ram_rdata, load_value;

    // With zero wait states the access completes on the accepting edge, so use live inputs.
    always_comb begin
        acc_write  = req_write;
        acc_funct3 = req_funct3;
        acc_addr   = req_addr;
        acc_wdata  = req_wdata;
        if (state == IDLE) begin
            acc_write  = MemWrite;
            acc_funct3 = Funct3;
            acc_addr   = Addr;
            acc_wdata  = WriteData;
        end
    end

    always_comb begin
        f3_ok = acc_write ? (acc_funct3 inside {F3_B, F3_H, F3_W})
                          : (acc_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (acc_funct3[1:0])
            2'b01:   aligned = ~acc_addr[0];
            2'b10:   aligned = (acc_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
`ifdef DMEM_MMIO_EN
        if (acc_addr == MMIO_ADDR) begin
            legal = (acc_funct3 == F3_W);
        end else begin
            legal = f3_ok & aligned & in_range;
        end
`else
        legal = f3_ok & aligned & in_range;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (MemReq) next_state = (WAIT_STATES > 0) ? WAIT : DONE;
            WAIT:    if (wait_cnt <= 8'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign finish_access = (next_state == DONE) && (state != DONE) && !reset;

`ifdef DMEM_MMIO_EN
    logic        mmio_hit;
    logic [31:0] mmio_q;

    assign mmio_hit   = (acc_addr == MMIO_ADDR);
    assign ram_we     = finish_access & legal & acc_write & ~mmio_hit;
    assign load_value = mmio_hit ? mmio_q : load_extend(ram_rdata, acc_addr[1:0], acc_funct3);
    assign MmioOut    = mmio_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_q <= '0;
        end else if (finish_access && legal && acc_write && mmio_hit) begin
            mmio_q <= acc_wdata;
        end
    end
`else
    assign ram_we     = finish_access & legal & acc_write;
    assign load_value = load_extend(ram_rdata, acc_addr[1:0], acc_funct3);
`endif

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .index(acc_addr[AW+1:2]),
        .we   (ram_we),
        .be   (byte_en(acc_addr[1:0], acc_funct3)),
        .wdata(store_align(acc_wdata, acc_funct3)),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            ReadData   <= '0;
            fault_q    <= 1'b0;
            req_write  <= 1'b0;
            req_funct3 <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && MemReq) begin
                req_write  <= MemWrite;
                req_funct3 <= Funct3;
                req_addr   <= Addr;
                req_wdata  <= WriteData;
                wait_cnt   <= WAIT_INIT;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            // Stores that complete legally keep the previous load result visible.
            if (finish_access) begin
                fault_q <= ~legal;
                if (!legal) begin
                    ReadData <= '0;
                end else if (!acc_write) begin
                    ReadData <= load_value;
                end
            end
        end
    end

    assign MemDone = (state == DONE);
    assign Fault   = (state == DONE) & fault_q;
    assign Stall   = MemReq & (state != DONE);

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: two instances (0 and 3 wait states) against a byte-array model.
// MMIO checks are enabled when DMEM_MMIO_EN is defined.
module tb_dmem_unit;

    localparam int DEPTH = 64;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        wr    [2];
    logic [2:0]  f3s   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rd    [2];
    logic        done  [2];
    logic        stall [2];
    logic        flt   [2];
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out [2];
    logic [31:0] mmio_m   [2];
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [2][DEPTH*4];
    logic [31:0] rd_m  [2];

    typedef struct {
        bit        w;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] exp_rd;
        bit        exp_flt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemWrite(wr[0]), .Funct3(f3s[0]),
        .Addr(addr[0]), .WriteData(wdat[0]), .ReadData(rd[0]), .MemDone(done[0]),
        .Stall(stall[0]), .Fault(flt[0])
`ifdef DMEM_MMIO_EN
        , .MmioOut(mmio_out[0])
`endif
    );

    dmem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemWrite(wr[1]), .Funct3(f3s[1]),
        .Addr(addr[1]), .WriteData(wdat[1]), .ReadData(rd[1]), .MemDone(done[1]),
        .Stall(stall[1]), .Fault(flt[1])
`ifdef DMEM_MMIO_EN
        , .MmioOut(mmio_out[1])
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: byte-addressed memory, rules applied directly from the access definition.
    function automatic void modelAccess(input int u, input bit w, input bit [2:0] f, input bit [31:0] a,
                                        input bit [31:0] wd, output bit [31:0] e_rd, output bit e_flt);
        int        size;
        bit        ok;
        bit [31:0] v;
        size = 1 << int'(f[1:0]);
        ok = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((a % 32'(size)) != 0) ok = 1'b0;
`ifdef DMEM_MMIO_EN
        if (a == 32'hFFFF_FFFC) ok = (f == 3'd2);
        else ok = ok && ((a >> 2) < 32'(DEPTH));
`else
        ok = ok && ((a >> 2) < 32'(DEPTH));
`endif
        if (!ok) begin
            e_rd    = 32'd0;
            e_flt   = 1'b1;
            rd_m[u] = 32'd0;
            return;
        end
        e_flt = 1'b0;
`ifdef DMEM_MMIO_EN
        if (a == 32'hFFFF_FFFC) begin
            if (w) mmio_m[u] = wd;
            else rd_m[u] = mmio_m[u];
            e_rd = rd_m[u];
            return;
        end
`endif
        if (w) begin
            for (int i = 0; i < size; i++) mem_m[u][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = size - 1; i >= 0; i--) v = (v << 8) | 32'(mem_m[u][int'(a) + i]);
            if (f == 3'd0) v = {{24{v[7]}}, v[7:0]};
            else if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
            rd_m[u] = v;
        end
        e_rd = rd_m[u];
    endfunction

    // Entered and left one time unit after a falling edge, with the unit idle.
    task automatic applyStimulus(input int u, input bit w, input bit [2:0] f, input bit [31:0] a,
                                 input bit [31:0] wd, output bit [31:0] g_rd, output bit g_flt);
        int ws, lat, stalls;
        bit seen;
        ws = (u == 0) ? WS0 : WS1;
        lat = 0; stalls = 0; seen = 1'b0;
        req[u] = 1'b1; wr[u] = w; f3s[u] = f; addr[u] = a; wdat[u] = wd;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (done[u]) begin
                seen = 1'b1;
                break;
            end
            if (stall[u]) stalls++;
            @(negedge clk);
            lat++;
        end
        g_rd  = rd[u];
        g_flt = flt[u];
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL u%0d_timeout actual=no MemDone expected=MemDone within 64 cycles", u);
            req[u] = 1'b0;
            @(negedge clk); #1;
            return;
        end
        checkOutput($sformatf("u%0d_latency", u), 32'(lat), 32'(ws + 1));
        checkOutput($sformatf("u%0d_stall_cycles", u), 32'(stalls), 32'(ws + 1));
        checkOutput($sformatf("u%0d_stall_in_done", u), 32'(stall[u]), 32'd0);
        req[u] = 1'b0;
        @(negedge clk); #1;
        checkOutput($sformatf("u%0d_done_pulse", u), 32'(done[u]), 32'd0);
        checkOutput($sformatf("u%0d_fault_pulse", u), 32'(flt[u]), 32'd0);
    endtask

    task automatic runAccess(input int u, input bit w, input bit [2:0] f, input bit [31:0] a,
                             input bit [31:0] wd, output bit [31:0] g_rd, output bit g_flt);
        bit [31:0] e_rd;
        bit        e_flt;
        applyStimulus(u, w, f, a, wd, g_rd, g_flt);
        modelAccess(u, w, f, a, wd, e_rd, e_flt);
        checkOutput($sformatf("u%0d_rd_%s_f%0d@%h", u, w ? "st" : "ld", f, a), g_rd, e_rd);
        checkOutput($sformatf("u%0d_fault_%s_f%0d@%h", u, w ? "st" : "ld", f, a), 32'(g_flt), 32'(e_flt));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [31:0] g_rd;
        bit        g_flt;

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; wr[u] = 1'b0; f3s[u] = 3'd0;
            addr[u] = 32'd0; wdat[u] = 32'd0; rd_m[u] = 32'd0;
`ifdef DMEM_MMIO_EN
            mmio_m[u] = 32'd0;
`endif
        end

        vecs.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h11, 32'hFFFFFF55, 32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h16, 32'h1234ABCD, 32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h14, 32'h0,        32'hABCD0505, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h12, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'd1, 32'h11, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0,       32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'd3, 32'h10, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'd2, 32'hFC, 32'h600DF00D, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'hFC, 32'h0,        32'h600DF00D, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'hFE, 32'h0,        32'h0000600D, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'hFD, 32'h0,        32'hFFFFFFF0, 1'b0});
`ifdef DMEM_MMIO_EN
        vecs.push_back('{1'b1, 3'd2, 32'hFFFFFFFC, 32'h000000A5, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        32'h000000A5, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'hFFFFFFFC, 32'h00000077, 32'h00000000, 1'b1});
`else
        vecs.push_back('{1'b1, 3'd2, 32'hFFFFFFFC, 32'h000000A5, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1});
`endif

        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d_reset_rd", u), rd[u], 32'd0);
            checkOutput($sformatf("u%0d_reset_done", u), 32'(done[u]), 32'd0);
            checkOutput($sformatf("u%0d_reset_fault", u), 32'(flt[u]), 32'd0);
            checkOutput($sformatf("u%0d_reset_stall", u), 32'(stall[u]), 32'd0);
`ifdef DMEM_MMIO_EN
            checkOutput($sformatf("u%0d_reset_mmio", u), mmio_out[u], 32'd0);
`endif
        end

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < DEPTH; i++) begin
                runAccess(u, 1'b1, 3'd2, 32'(4 * i), 32'(32'h01010101 * i), g_rd, g_flt);
            end
        end

        for (int n = 0; n < vecs.size(); n++) begin
            runAccess(0, vecs[n].w, vecs[n].f3, vecs[n].a, vecs[n].wd, g_rd, g_flt);
            checkOutput($sformatf("vec%0d_rd", n), g_rd, vecs[n].exp_rd);
            checkOutput($sformatf("vec%0d_fault", n), 32'(g_flt), 32'(vecs[n].exp_flt));
        end
`ifdef DMEM_MMIO_EN
        checkOutput("mmio_out_u0", mmio_out[0], 32'h000000A5);
        checkOutput("mmio_out_u1", mmio_out[1], 32'h00000000);
`endif

        // MemReq held through DONE must not start a new access until the following IDLE cycle.
        req[0] = 1'b1; wr[0] = 1'b0; f3s[0] = 3'd2; addr[0] = 32'h10; wdat[0] = 32'd0;
        @(negedge clk); #1;
        checkOutput("hold_done_first", 32'(done[0]), 32'd1);
        @(negedge clk); #1;
        checkOutput("hold_idle_done", 32'(done[0]), 32'd0);
        checkOutput("hold_idle_stall", 32'(stall[0]), 32'd1);
        @(negedge clk); #1;
        checkOutput("hold_done_second", 32'(done[0]), 32'd1);
        checkOutput("hold_rd", rd[0], 32'hDEAD55EF);
        req[0] = 1'b0;
        rd_m[0] = 32'hDEAD55EF;
        @(negedge clk); #1;

        // Reset during a slow store: once mid-wait, once on the completing edge.
        runAccess(1, 1'b0, 3'd2, 32'h20, 32'd0, g_rd, g_flt);
        for (int cyc = 2; cyc <= 3; cyc++) begin
            req[1] = 1'b1; wr[1] = 1'b1; f3s[1] = 3'd2;
            addr[1] = (cyc == 2) ? 32'h20 : 32'h24; wdat[1] = 32'hCAFEF00D;
            repeat (cyc) @(negedge clk);
            rst[1] = 1'b1;
            @(negedge clk);
            rst[1] = 1'b0;
            req[1] = 1'b0;
            #1;
            checkOutput($sformatf("abort%0d_rd", cyc), rd[1], 32'd0);
            checkOutput($sformatf("abort%0d_done", cyc), 32'(done[1]), 32'd0);
            checkOutput($sformatf("abort%0d_stall", cyc), 32'(stall[1]), 32'd0);
            rd_m[1] = 32'd0;
        end
        runAccess(1, 1'b0, 3'd2, 32'h20, 32'd0, g_rd, g_flt);
        checkOutput("abort_old_20", g_rd, 32'h08080808);
        runAccess(1, 1'b0, 3'd2, 32'h24, 32'd0, g_rd, g_flt);
        checkOutput("abort_old_24", g_rd, 32'h09090909);

        for (int n = 0; n < 200; n++) begin
            int        u;
            bit        w;
            bit [2:0]  f;
            bit [31:0] a;
            bit [31:0] wd;
            u = (n % 4 == 3) ? 1 : 0;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                f = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0:       f = 3'd0;
                    1:       f = 3'd1;
                    2:       f = 3'd2;
                    3:       f = 3'd4;
                    default: f = 3'd5;
                endcase
            end
            a = 32'($urandom_range(0, DEPTH + 3)) << 2;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            else if (f[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (f[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFFC;
            wd = $urandom;
            runAccess(u, w, f, a, wd, g_rd, g_flt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
